// File: rtl/midi_uart_rx.sv
// midi_uart_rx: oversampling 8N1 receiver for the MIDI IN line (LSB first, idle high).
// Define MIDI_RX_GLITCH_FILTER_EN for a 2-of-3 majority vote around every sample point.
module midi_uart_rx #(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD        = 31250,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] d_out,
  output logic       d_valid,
  output logic       f_error
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF         = CLKS_PER_BIT / 2;
`ifdef MIDI_RX_GLITCH_FILTER_EN
  localparam int FILT = 1;
`else
  localparam int FILT = 0;
`endif
  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  // With the filter the decision lands one count past the nominal point; reloading
  // with FILT keeps the sample grid anchored to the start bit.
  localparam logic [CNT_W-1:0] START_END  = CNT_W'(HALF - 1 + FILT);
  localparam logic [CNT_W-1:0] BIT_END    = CNT_W'(CLKS_PER_BIT - 1 + FILT);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FILT);

  if (CLKS_PER_BIT < 8) begin : g_cpb_check
    $error("midi_uart_rx: CLK_FREQ/BAUD must be at least 8");
  end
  if (SYNC_STAGES < 2) begin : g_sync_check
    $error("midi_uart_rx: SYNC_STAGES must be at least 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               rx_s;
  logic               smp;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         bit_cnt;
  logic [7:0]         shreg;
  logic               at_start_pt;
  logic               at_bit_pt;
  logic               shift_en;
  logic               load;
  logic               valid_set;
  logic               err_set;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end
  assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef MIDI_RX_GLITCH_FILTER_EN
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // hist[1]/hist[0] hold rx_s from the counts S-1 and S when the vote is taken at S+1.
  logic [1:0] hist;
  always_ff @(posedge clk) hist <= {hist[0], rx_s};
  assign smp = maj3(hist[1], hist[0], rx_s);
`else
  assign smp = rx_s;
`endif

  assign at_start_pt = (cnt == START_END);
  assign at_bit_pt   = (cnt == BIT_END);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      START:   if (at_start_pt) state_nxt = smp ? IDLE : DATA;
      DATA:    if (at_bit_pt && bit_cnt == 3'd7) state_nxt = STOP;
      STOP:    if (at_bit_pt) state_nxt = smp ? IDLE : BREAK;
      BREAK:   if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shift_en  = 1'b0;
    load      = 1'b0;
    valid_set = 1'b0;
    err_set   = 1'b0;
    case (state)
      DATA: shift_en = at_bit_pt;
      STOP: begin
        load      = at_bit_pt;
        valid_set = at_bit_pt & smp;
        err_set   = at_bit_pt & ~smp;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        START:      cnt <= at_start_pt ? CNT_RELOAD : cnt + CNT_W'(1);
        DATA, STOP: cnt <= at_bit_pt ? CNT_RELOAD : cnt + CNT_W'(1);
        default:    cnt <= '0;
      endcase
      if (state == START)  bit_cnt <= '0;
      else if (shift_en)   bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) shreg <= {smp, shreg[7:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_out   <= 8'h00;
      d_valid <= 1'b0;
      f_error <= 1'b0;
    end else begin
      d_valid <= valid_set;
      f_error <= err_set;
      if (load) d_out <= shreg;
    end
  end

endmodule

// File: tb/tb_midi_uart_rx.sv
// tb_midi_uart_rx: builds the whole rx waveform up front, derives expected strobes from it
// with a bit-timing model, then replays the waveform while a monitor scores the DUT.
module tb_midi_uart_rx;

  localparam int TB_CLK  = 1000000;
  localparam int TB_BAUD = 31250;
  localparam int CPB     = TB_CLK / TB_BAUD;
  localparam int HALF    = CPB / 2;
  localparam int SYNC    = 2;
  localparam int MAXN    = 40000;
`ifdef MIDI_RX_GLITCH_FILTER_EN
  localparam int FILT = 1;
`else
  localparam int FILT = 0;
`endif

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic       clk = 1'b1;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] d_out;
  logic       d_valid;
  logic       f_error;

  logic       line_w [MAXN];
  logic       rst_w  [MAXN];
  int         n = 0;
  int         cyc = 0;
  exp_t       exp_q[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] hold = 8'h00;
  bit         done = 1'b0;

  midi_uart_rx #(
    .CLK_FREQ   (TB_CLK),
    .BAUD       (TB_BAUD),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .rx     (rx),
    .d_out  (d_out),
    .d_valid(d_valid),
    .f_error(f_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic put(input logic v, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      if (n < MAXN) begin
        line_w[n] = v;
        rst_w[n]  = 1'b0;
        n++;
      end
    end
  endtask

  task automatic put_frame(input logic [7:0] b, input logic stop);
    put(1'b0, CPB);
    for (int k = 0; k < 8; k++) put(b[k], CPB);
    put(stop, CPB);
  endtask

  function automatic logic lv(input int idx);
    return (idx >= 0 && idx < n) ? line_w[idx] : 1'b1;
  endfunction

  // Line level as seen at a bit centre (majority of the three neighbours when filtering).
  function automatic logic centre(input int c);
    if (FILT != 0) return (lv(c-1) & lv(c)) | (lv(c-1) & lv(c+1)) | (lv(c) & lv(c+1));
    return lv(c);
  endfunction

  function automatic int find_rst(input int lo, input int hi);
    for (int r = lo; r <= hi && r < n; r++) if (rst_w[r]) return r;
    return -1;
  endfunction

  // A low level starts a frame; bit k is read at first_low + HALF + k*CPB. The strobe shows
  // SYNC+1 cycles after the last line index the decision depends on.
  task automatic run_model();
    int   j;
    exp_t e;
    j = 0;
    while (j < n) begin
      int         i;
      int         r;
      int         u;
      int         h;
      logic [7:0] b;
      logic       stop;
      i = j;
      while (i < n && line_w[i]) i++;
      if (i >= n) break;
      if (centre(i + HALF)) begin
        u = i + HALF + FILT;
        r = find_rst(i, u + SYNC);
        j = (r >= 0) ? r + 1 : u + 1;
        continue;
      end
      for (int k = 0; k < 8; k++) b[k] = centre(i + HALF + (k + 1) * CPB);
      stop = centre(i + HALF + 9 * CPB);
      u    = i + HALF + 9 * CPB + FILT;
      h    = u + 1;
      if (!stop) while (h < n && !line_w[h]) h++;
      r = find_rst(i, stop ? u + SYNC : h + SYNC);
      if (r < 0 || r > u + SYNC) begin
        e.cyc  = u + SYNC + 1;
        e.data = b;
        e.err  = !stop;
        exp_q.push_back(e);
      end
      if (r >= 0) j = r + 1;
      else        j = stop ? u + 1 : h + 1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  initial begin
    int         f5;
    int         s6;
    logic [7:0] b;
    logic       good;

    put(1'b1, 50);
    for (int k = 0; k < 5; k++) rst_w[k] = 1'b1;

    put_frame(8'h91, 1'b1);
    put(1'b1, 3 * CPB);

    put_frame(8'h91, 1'b1);
    put_frame(8'h3C, 1'b1);
    put_frame(8'h64, 1'b1);
    put(1'b1, 3 * CPB);

    // Short low pulse, well under half a bit: a false start.
    put(1'b0, CPB / 8);
    put(1'b1, 2 * CPB);
    put_frame(8'h80, 1'b1);
    put(1'b1, 2 * CPB);

    put_frame(8'h55, 1'b0);
    put(1'b0, 5 * CPB);
    put(1'b1, 2 * CPB);
    put_frame(8'hF8, 1'b1);
    put(1'b1, 2 * CPB);

    // Reset mid data bit 4 of 0xA5. The tail of that frame is still on the line, so its
    // d5->d6 falling edge is picked up as a fresh frame; the model predicts that outcome.
    f5 = n;
    put_frame(8'hA5, 1'b1);
    put(1'b1, 12 * CPB);
    rst_w[f5 + 5 * CPB + HALF] = 1'b1;
    put_frame(8'h7F, 1'b1);
    put(1'b1, 2 * CPB);

    // One-cycle low spike exactly on the bit-3 sample point.
    s6 = n;
    put_frame(8'hFF, 1'b1);
    line_w[s6 + HALF + 4 * CPB] = 1'b0;
    put(1'b1, 2 * CPB);

    for (int f = 0; f < 40; f++) begin
      b    = 8'($urandom);
      good = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 5) == 0) begin
        put(1'b0, int'($urandom_range(1, 3)));
        put(1'b1, CPB);
      end
      put_frame(b, good);
      if (!good) begin
        put(1'b0, int'($urandom_range(0, CPB)));
        put(1'b1, int'($urandom_range(CPB / 2, CPB)));
      end
      put(1'b1, int'($urandom_range(0, 2 * CPB)));
    end
    put(1'b1, 4 * CPB);

    run_model();

    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rx    = line_w[c];
      reset = rst_w[c];
    end
    repeat (2) @(negedge clk);
    done = 1'b1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (cyc >= 1 && cyc - 1 < n && rst_w[cyc-1]) hold = 8'h00;
    if (done) begin
      check("outstanding_strobes", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end else if (cyc == 5) begin
      check("reset_d_out", d_out, 8'h00);
      check("reset_d_valid", d_valid, 1'b0);
      check("reset_f_error", f_error, 1'b0);
    end else if (cyc > 5) begin
      if (d_valid || f_error) begin
        check("strobe_exclusive", d_valid & f_error, 1'b0);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {d_valid, f_error, d_out}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind_f_error", f_error, e.err);
          check("strobe_data", d_out, e.data);
          check("strobe_cycle", cyc, e.cyc);
          hold = e.data;
        end
      end else begin
        check("d_out_hold", d_out, hold);
      end
    end
  end

endmodule
